fetch_sequencer: RTL

Sequencer for the pipeline's fetch stage. Owns the program counter, issues instruction-memory requests over a req/ack handshake, and loads the F/D pipeline register. Applies redirects from the execute-stage controller (next PC from the ALU instead of PC+4), flushes wrong-path fetches and honours decode stalls. It replaces the purely combinational next-PC select with a stateful controller that also drains in-flight fetches.

---
 rtl/fetch_sequencer_pkg.sv | 18 +
 rtl/fetch_skid_buf.sv | 42 ++++
 rtl/fetch_sequencer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: state encoding, datapath width
// and the canonical no-op instruction.
package fetch_sequencer_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] DEFAULT_NOP_INST = 32'h0000_0013;

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SKID  = 3'd3,
        ST_DRAIN = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for an instruction word and its PC, used when an
// instruction returns while the F/D register is still occupied.
module fetch_skid_buf
    import fetch_sequencer_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_unload,
    input  logic            i_clear,
    input  logic [XLEN-1:0] i_inst,
    input  logic [XLEN-1:0] i_pc,
    output logic            o_valid,
    output logic [XLEN-1:0] o_inst,
    output logic [XLEN-1:0] o_pc
);

    logic            r_valid;
    logic [XLEN-1:0] r_inst;
    logic [XLEN-1:0] r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_inst  <= '0;
            r_pc    <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_inst  <= i_inst;
            r_pc    <= i_pc;
        end else if (i_unload) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_inst  = r_inst;
    assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: owns the PC, issues req/ack instruction fetches and
// loads the F/D register. Define FETCH_SEQ_PERF_EN for redirect/stall counters.
//
// state | meaning
// BOOT  | first cycle after reset, no request
// REQ   | may issue a request for pc
// WAIT  | request outstanding, held until ack
// SKID  | response parked, F/D register blocked
// DRAIN | outstanding request is wrong-path, response discarded
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INST = DEFAULT_NOP_INST
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            x_redirect,
    input  logic [XLEN-1:0] x_target,
    input  logic            d_stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            fd_valid,
    output logic [XLEN-1:0] fd_inst,
    output logic [XLEN-1:0] fd_pc,
    output logic            pc_sel
`ifdef FETCH_SEQ_PERF_EN
    ,
    output logic [XLEN-1:0] perf_redirects,
    output logic [XLEN-1:0] perf_stall_cycles
`endif
);

    fetch_state_t    r_state;
    fetch_state_t    w_next_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_req_addr;
    logic            r_fd_valid;
    logic [XLEN-1:0] r_fd_inst;
    logic [XLEN-1:0] r_fd_pc;

    logic            w_slot_free;
    logic            w_req;
    logic [XLEN-1:0] w_addr;
    logic            w_pc_inc;
    logic            w_fd_load;
    logic [XLEN-1:0] w_fd_inst;
    logic [XLEN-1:0] w_fd_pc;
    logic            w_skid_load;
    logic            w_skid_unload;
    logic            w_skid_valid;
    logic [XLEN-1:0] w_skid_inst;
    logic [XLEN-1:0] w_skid_pc;

    // Free when empty or when decode consumes the current entry this cycle.
    assign w_slot_free = !r_fd_valid || !d_stall;

    always_comb begin
        w_next_state  = r_state;
        w_req         = 1'b0;
        w_addr        = r_pc;
        w_pc_inc      = 1'b0;
        w_fd_load     = 1'b0;
        w_fd_inst     = imem_rdata;
        w_fd_pc       = r_pc;
        w_skid_load   = 1'b0;
        w_skid_unload = 1'b0;

        case (r_state)
            ST_BOOT: begin
                w_next_state = ST_REQ;
            end
            ST_REQ: begin
                if (w_slot_free) begin
                    w_req = 1'b1;
                    if (imem_ack) begin
                        w_fd_load = 1'b1;
                        w_pc_inc  = 1'b1;
                    end else begin
                        w_next_state = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                w_req   = 1'b1;
                w_addr  = r_req_addr;
                w_fd_pc = r_req_addr;
                if (imem_ack) begin
                    w_pc_inc = 1'b1;
                    if (w_slot_free) begin
                        w_fd_load    = 1'b1;
                        w_next_state = ST_REQ;
                    end else begin
                        w_skid_load  = 1'b1;
                        w_next_state = ST_SKID;
                    end
                end
            end
            ST_SKID: begin
                if (w_slot_free && w_skid_valid) begin
                    w_fd_load     = 1'b1;
                    w_fd_inst     = w_skid_inst;
                    w_fd_pc       = w_skid_pc;
                    w_skid_unload = 1'b1;
                    w_next_state  = ST_REQ;
                end
            end
            ST_DRAIN: begin
                w_req  = 1'b1;
                w_addr = r_req_addr;
                if (imem_ack) begin
                    w_next_state = ST_REQ;
                end
            end
            default: begin
                w_next_state = ST_BOOT;
            end
        endcase

        // A flush overrides every other action. Only a request that is still
        // unanswered at the end of this cycle leaves something to drain.
        if (x_redirect) begin
            w_pc_inc      = 1'b0;
            w_fd_load     = 1'b0;
            w_skid_load   = 1'b0;
            w_skid_unload = 1'b0;
            if (w_req && !imem_ack) begin
                w_next_state = ST_DRAIN;
            end else begin
                w_next_state = ST_REQ;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_fd_valid <= 1'b0;
            r_fd_inst  <= NOP_INST;
            r_fd_pc    <= '0;
        end else begin
            r_state <= w_next_state;

            if (x_redirect) begin
                r_pc <= x_target;
            end else if (w_pc_inc) begin
                r_pc <= r_pc + 32'd4;
            end

            if (r_state == ST_REQ && w_req) begin
                r_req_addr <= r_pc;
            end

            if (x_redirect) begin
                r_fd_valid <= 1'b0;
            end else if (w_fd_load) begin
                r_fd_valid <= 1'b1;
                r_fd_inst  <= w_fd_inst;
                r_fd_pc    <= w_fd_pc;
            end else if (w_slot_free) begin
                r_fd_valid <= 1'b0;
            end
        end
    end

    fetch_skid_buf u_skid (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_skid_load),
        .i_unload (w_skid_unload),
        .i_clear  (x_redirect),
        .i_inst   (imem_rdata),
        .i_pc     (r_req_addr),
        .o_valid  (w_skid_valid),
        .o_inst   (w_skid_inst),
        .o_pc     (w_skid_pc)
    );

    assign imem_req  = w_req;
    assign imem_addr = w_addr;
    assign fd_valid  = r_fd_valid;
    assign fd_inst   = r_fd_valid ? r_fd_inst : NOP_INST;
    assign fd_pc     = r_fd_pc;
    assign pc_sel    = x_redirect;

`ifdef FETCH_SEQ_PERF_EN
    logic [XLEN-1:0] r_perf_redirects;
    logic [XLEN-1:0] r_perf_stall_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_redirects    <= '0;
            r_perf_stall_cycles <= '0;
        end else begin
            if (x_redirect) begin
                r_perf_redirects <= r_perf_redirects + 32'd1;
            end
            if (r_fd_valid && d_stall) begin
                r_perf_stall_cycles <= r_perf_stall_cycles + 32'd1;
            end
        end
    end

    assign perf_redirects    = r_perf_redirects;
    assign perf_stall_cycles = r_perf_stall_cycles;
`endif

endmodule
